fp_divider: RTL and testbench

Sequential IEEE-754 single-precision divider, the inverse companion of the FP multiplier in the FPU arithmetic path. It computes Out = A / B with a restoring radix-2 mantissa divider that resolves one quotient bit per clock. Results are truncated toward zero, matching the multiplier's rounding. A start/busy/done handshake lets the FPU issue control launch an operation and later collect the result.

---
 rtl/fp_divider.sv | 166 ++++++++++++++++
 tb/tb_fp_divider.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_divider.sv
// Sequential IEEE-754 single-precision divider: restoring radix-2, one quotient bit per clock, truncating.
// Define FP_DIV_SPECIAL_EN for zero/inf/NaN decode, over/underflow clamping and the 2-cycle special path.
module fp_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, PACK = 2'd2} state_t;

  state_t             state_q, state_d;
  logic        [4:0]  cnt_q, cnt_d;
  logic        [24:0] rem_q, rem_d;
  logic        [24:0] q_q, q_d;
  logic        [23:0] divs_q, divs_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  ebase_q, ebase_d;
  logic        [31:0] out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef FP_DIV_SPECIAL_EN
  logic               spec_q, spec_d;
  logic        [31:0] spec_val_q, spec_val_d;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
`endif

  logic               ge;
  logic signed [9:0]  e_fin;
  logic        [22:0] frac;
  logic        [31:0] result;

  // Datapath and result packing.
  always_comb begin
    ge    = rem_q >= {1'b0, divs_q};
    e_fin = ebase_q + {9'd0, q_q[24]};
    frac  = q_q[24] ? q_q[23:1] : q_q[22:0];
`ifdef FP_DIV_SPECIAL_EN
    if (spec_q)
      result = spec_val_q;
    else if (e_fin >= 10'sd255)
      result = {sign_q, 8'hFF, 23'h0};
    else if (e_fin <= 10'sd0)
      result = {sign_q, 31'h0};
    else
      result = {sign_q, e_fin[7:0], frac};
`else
    result = {sign_q, e_fin[7:0], frac};
`endif
  end

`ifdef FP_DIV_SPECIAL_EN
  always_comb begin
    a_zero = (A[30:23] == 8'h00);
    b_zero = (B[30:23] == 8'h00);
    a_inf  = (A[30:23] == 8'hFF) && (A[22:0] == 23'h0);
    b_inf  = (B[30:23] == 8'hFF) && (B[22:0] == 23'h0);
    a_nan  = (A[30:23] == 8'hFF) && (A[22:0] != 23'h0);
    b_nan  = (B[30:23] == 8'hFF) && (B[22:0] != 23'h0);
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    divs_d  = divs_q;
    sign_d  = sign_q;
    ebase_d = ebase_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef FP_DIV_SPECIAL_EN
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = A[31] ^ B[31];
          divs_d  = {1'b1, B[22:0]};
          rem_d   = {1'b0, 1'b1, A[22:0]};
          q_d     = 25'd0;
          cnt_d   = 5'd24;
          // Base assumes q[24]=0; the packing stage adds one when it is set.
          ebase_d = {2'b00, A[30:23]} - {2'b00, B[30:23]} + 10'd126;
          busy_d  = 1'b1;
          state_d = DIV;
`ifdef FP_DIV_SPECIAL_EN
          spec_d     = 1'b1;
          spec_val_d = 32'h0;
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            spec_val_d = 32'h7FC00000;
          else if (b_zero || a_inf)
            spec_val_d = {A[31] ^ B[31], 8'hFF, 23'h0};
          else if (a_zero || b_inf)
            spec_val_d = {A[31] ^ B[31], 31'h0};
          else
            spec_d = 1'b0;
          if (spec_d)
            state_d = PACK;
`endif
        end
      end
      DIV: begin
        rem_d = (ge ? rem_q - {1'b0, divs_q} : rem_q) << 1;
        q_d   = {q_q[23:0], ge};
        if (cnt_q == 5'd0)
          state_d = PACK;
        else
          cnt_d = cnt_q - 5'd1;
      end
      PACK: begin
        out_d   = result;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 25'd0;
      q_q     <= 25'd0;
      divs_q  <= 24'd0;
      sign_q  <= 1'b0;
      ebase_q <= 10'sd0;
      out_q   <= 32'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FP_DIV_SPECIAL_EN
      spec_q     <= 1'b0;
      spec_val_q <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      divs_q  <= divs_d;
      sign_q  <= sign_d;
      ebase_q <= ebase_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FP_DIV_SPECIAL_EN
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
`endif
    end
  end

  assign Out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_fp_divider.sv
// Bench for fp_divider: behavioural quotient model, per-cycle compare of done/busy/Out, directed and random operations.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic [31:0] Out;
  logic        busy;
  logic        done;

  fp_divider dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Out  (Out),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_out  = 32'h0;
  logic [31:0] m_val  = 32'h0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_pend = 1'b0;
  int          m_left = 0;

  // Quotient straight from the real-number rules: q = floor(coeffA * 2^24 / coeffB).
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, output int lat);
    logic        s;
    int          ea, eb, e;
    logic [63:0] ca, cb, q;
    logic [22:0] fr;
`ifdef FP_DIV_SPECIAL_EN
    logic        az, bz, ainf, binf, anan, bnan;
`endif
    s   = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    lat = 26;
`ifdef FP_DIV_SPECIAL_EN
    az   = (ea == 0);
    bz   = (eb == 0);
    ainf = (ea == 255) && (a[22:0] == 23'h0);
    binf = (eb == 255) && (b[22:0] == 23'h0);
    anan = (ea == 255) && (a[22:0] != 23'h0);
    bnan = (eb == 255) && (b[22:0] != 23'h0);
    lat  = 1;
    if (anan || bnan || (az && bz) || (ainf && binf)) return 32'h7FC00000;
    if (bz || ainf) return {s, 8'hFF, 23'h0};
    if (az || binf) return {s, 31'h0};
    lat = 26;
`endif
    ca = {40'd0, 1'b1, a[22:0]};
    cb = {40'd0, 1'b1, b[22:0]};
    q  = (ca << 24) / cb;
    if (q >= 64'h1000000) begin
      fr = q[23:1];
      e  = ea - eb + 127;
    end else begin
      fr = q[22:0];
      e  = ea - eb + 126;
    end
`ifdef FP_DIV_SPECIAL_EN
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
`endif
    return {s, 8'(e), fr};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  e;
    logic [31:0] fr;
    case ($urandom_range(0, 7))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'h01;
      3:       e = 8'hFE;
      default: e = 8'($urandom_range(1, 254));
    endcase
    fr = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
    return {1'($urandom_range(0, 1)), e, fr[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one operation, optionally re-pulsing start while busy, and waits (bounded) for done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want,
                        input int want_lat, input int intr_at);
    int lat;
    bit found;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    lat = 0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      start = (intr_at > 0) && (lat == intr_at);
      if (start) begin
        A = 32'h3F800000;
        B = 32'h40400000;
      end
      if (done === 1'b1) found = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    start = 1'b0;
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done for %h / %h within 60 cycles", a, b);
    end else begin
      chk("latency", 32'(lat), 32'(want_lat));
      chk("result", Out, want);
    end
  endtask

  initial begin
    int n;
    int l;
    logic [31:0] w;

    #3 rst_n = 1'b0;
    #1;
    chk("reset_out", Out, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);

    fork
      begin : model
        int lt;
        forever begin
          @(posedge clk or negedge rst_n);
          if (!rst_n) begin
            m_pend = 1'b0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_out  = 32'h0;
          end else begin
            m_done = 1'b0;
            if (m_pend) begin
              m_left--;
              if (m_left == 0) begin
                m_pend = 1'b0;
                m_out  = m_val;
                m_done = 1'b1;
              end
            end else if (start) begin
              m_val  = ref_div(A, B, lt);
              m_left = lt;
              m_pend = 1'b1;
            end
            m_busy = m_pend;
          end
        end
      end
      begin : compare
        forever begin
          @(negedge clk);
          chk("done", {31'd0, done}, {31'd0, m_done});
          chk("busy", {31'd0, busy}, {31'd0, m_busy});
          chk("out", Out, m_out);
        end
      end
    join_none

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 26, 0);
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26, 0);
    run_op(32'hBFC00000, 32'h3F000000, 32'hC0400000, 26, 0);
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 26, 10);

    // Abort mid-operation with reset; nothing may complete afterwards.
    @(negedge clk);
    A = 32'h40C00000;
    B = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out", Out, 32'h0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    chk("no_done_after_abort", 32'(n), 32'd0);
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 26, 0);

`ifdef FP_DIV_SPECIAL_EN
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0);
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 1, 0);
    run_op(32'h7F000000, 32'h00800000, 32'h7F800000, 26, 0);
`else
    w = ref_div(32'h7F000000, 32'h00800000, l);
    run_op(32'h7F000000, 32'h00800000, w, 26, 0);
    w = ref_div(32'h3F800000, 32'h00000000, l);
    run_op(32'h3F800000, 32'h00000000, w, 26, 0);
`endif

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 4) == 0);
      A = rnd_fp();
      B = rnd_fp();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
